// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM state type and small helpers for the multiply/divide controller.
package mdu_ctrl_pkg;

  localparam logic [7:0] ALUOP_MFHI  = 8'h10;
  localparam logic [7:0] ALUOP_MTHI  = 8'h11;
  localparam logic [7:0] ALUOP_MFLO  = 8'h12;
  localparam logic [7:0] ALUOP_MTLO  = 8'h13;
  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1a;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1b;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdu_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  // Magnitude of v when it is treated as signed, otherwise v unchanged.
  function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, abortable in one cycle.
module mdu_ctrl_div_iter #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     quot_q, quot_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     dvs_q, dvs_d;
  logic [32:0]     rem_sh, diff;
  logic            qbit;
  logic [31:0]     quot_step, rem_step;

  always_comb begin
    rem_sh    = {rem_q, quot_q[31]};
    diff      = rem_sh - {1'b0, dvs_q};
    qbit      = ~diff[32];
    rem_step  = qbit ? diff[31:0] : rem_sh[31:0];
    quot_step = {quot_q[30:0], qbit};

    busy_d = busy_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(DIV_CYCLES);
      quot_d = dividend;
      rem_d  = 32'd0;
      dvs_d  = divisor;
    end else if (busy_q) begin
      quot_d = quot_step;
      rem_d  = rem_step;
      cnt_d  = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_d = 1'b0;
    end
  end

  // The last iteration's result is presented combinationally so the caller can
  // capture it in the same cycle.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CntW'(1));
  assign quot = quot_step;
  assign rem  = rem_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, sequences MULT/DIV and stalls the pipe.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        stallE,
  input  logic [7:0]  aluopE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stall_o,
  output logic [31:0] hilo_rd_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic        is_mul, is_div, is_signed, start;
  logic [63:0] prod;
  logic        div_start, div_abort, div_busy, div_done;
  logic [31:0] div_quot, div_rem;

  mdu_ctrl_div_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .abort   (div_abort),
    .dividend(mag32(is_signed, srcaE)),
    .divisor (mag32(is_signed, srcbE)),
    .busy    (div_busy),
    .done    (div_done),
    .quot    (div_quot),
    .rem     (div_rem)
  );

  always_comb begin
    is_mul    = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_MULTU);
    is_div    = (aluopE == ALUOP_DIV) || (aluopE == ALUOP_DIVU);
    is_signed = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_DIV);
    start     = (state_q == StIdle) && !flushE && (is_mul || is_div);
    stall_o   = start || (((state_q == StMul) || (state_q == StDiv)) && !flushE);
    hilo_rd_o = (aluopE == ALUOP_MFHI) ? hi_q : lo_q;
    // Sign-extending both operands to 64 bits makes one unsigned multiply serve both flavours.
    prod      = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_start = 1'b0;
    div_abort = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d   = srcaE;
          b_d   = srcbE;
          sgn_d = is_signed;
          if (is_mul) begin
            state_d = StMul;
            cnt_d   = CntW'(MUL_CYCLES);
          end else begin
            state_d   = StDiv;
            div_start = (srcbE != 32'd0);
          end
        end else if (!stallE && !flushE) begin
          if (aluopE == ALUOP_MTHI) hi_d = srcaE;
          if (aluopE == ALUOP_MTLO) lo_d = srcaE;
        end
      end
      StMul: begin
        if (flushE) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(1)) begin
          {res_hi_d, res_lo_d} = prod;
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDiv: begin
        if (flushE) begin
          state_d   = StIdle;
          cnt_d     = '0;
          div_abort = 1'b1;
        end else if (b_q == 32'd0) begin
          res_hi_d = a_q;
          res_lo_d = 32'hffff_ffff;
          state_d  = StDone;
        end else if (div_busy && div_done) begin
          // Quotient sign follows the operand signs; remainder follows the dividend.
          res_lo_d = (sgn_q && (a_q[31] ^ b_q[31])) ? neg32(div_quot) : div_quot;
          res_hi_d = (sgn_q && a_q[31]) ? neg32(div_rem) : div_rem;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (flushE) begin
          state_d = StIdle;
        end else if (!stallE) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: pipeline-like driver, reference model, decoupled monitor.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MulCycles = 3;
  localparam int DivCycles = 32;
  localparam logic [7:0] OpNop = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flushE = 1'b0;
  logic        stallE = 1'b0;
  logic [7:0]  aluopE = OpNop;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        stall_o;
  logic [31:0] hilo_rd_o, hi_o, lo_o;

  mdu_ctrl #(
    .MUL_CYCLES(MulCycles),
    .DIV_CYCLES(DivCycles)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flushE   (flushE),
    .stallE   (stallE),
    .aluopE   (aluopE),
    .srcaE    (srcaE),
    .srcbE    (srcbE),
    .stall_o  (stall_o),
    .hilo_rd_o(hilo_rd_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    int          stall;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        e_valid = 1'b0;
  logic        timed_out = 1'b0;
  logic        done_all = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_muldiv(input logic [7:0] op);
    return op == ALUOP_MULT || op == ALUOP_MULTU || op == ALUOP_DIV || op == ALUOP_DIVU;
  endfunction

  function automatic int latency(input logic [7:0] op, input logic [31:0] b);
    if (op == ALUOP_MULT || op == ALUOP_MULTU) return 1 + MulCycles;
    if (op == ALUOP_DIV || op == ALUOP_DIVU) return (b == 32'd0) ? 2 : 1 + DivCycles;
    return 0;
  endfunction

  // Architectural result of a mul/div, straight from integer arithmetic.
  function automatic void ref_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    hi = '0;
    lo = '0;
    if (op == ALUOP_MULT) begin
      p = sa * sb;
      w = p;
      {hi, lo} = w;
    end else if (op == ALUOP_MULTU) begin
      up = ua * ub;
      {hi, lo} = up;
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hffff_ffff;
    end else if (op == ALUOP_DIV) begin
      q  = sa / sb;
      r  = sa % sb;
      w  = q;
      lo = w[31:0];
      w  = r;
      hi = w[31:0];
    end else begin
      up = ua / ub;
      w  = up;
      lo = w[31:0];
      up = ua % ub;
      w  = up;
      hi = w[31:0];
    end
  endfunction

  // Compute the expected outcome, push it, then present the instruction until it leaves E.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input int st_from, input int st_len, input int rst_at);
    exp_t        e;
    int          lat, endc, kind;
    logic [31:0] rhi, rlo;
    bit          left;
    if (timed_out) return;
    lat  = latency(op, b);
    endc = -1;
    kind = 0;
    for (int c = 0; c < 200 && endc < 0; c++) begin
      if (c == rst_at) begin
        endc = c; kind = 2;
      end else if (c == flush_at) begin
        endc = c; kind = 1;
      end else if (c >= lat && !(c >= st_from && c < st_from + st_len)) begin
        endc = c; kind = 0;
      end
    end
    e.op = op;
    e.rd = (op == ALUOP_MFHI) ? m_hi : m_lo;
    if (kind == 2) e.stall = (endc < lat) ? endc + 1 : lat;
    else e.stall = (endc < lat) ? endc : lat;
    if (kind == 0) begin
      if (is_muldiv(op)) begin
        ref_op(op, a, b, rhi, rlo);
        m_hi = rhi;
        m_lo = rlo;
      end else if (op == ALUOP_MTHI) begin
        m_hi = a;
      end else if (op == ALUOP_MTLO) begin
        m_lo = a;
      end
    end else if (kind == 2) begin
      m_hi = '0;
      m_lo = '0;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);

    left = 1'b0;
    for (int c = 0; c < 200 && !left; c++) begin
      @(posedge clk);
      #1;
      e_valid = 1'b1;
      aluopE  = op;
      srcaE   = a;
      srcbE   = b;
      stallE  = (c >= st_from) && (c < st_from + st_len);
      flushE  = (c == flush_at);
      rst     = (c == rst_at);
      @(negedge clk);
      left = rst || flushE || (!stall_o && !stallE);
    end
    if (!left) begin
      n_tests++;
      n_fail++;
      timed_out = 1'b1;
      $display("FAIL timeout: op %h never left E, expected within 200 cycles", op);
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 100);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts stall cycles of the instruction in E and checks it as it leaves.
  initial begin : monitor
    exp_t pend;
    int   stall_cnt;
    bit   chk_pend;
    stall_cnt = 0;
    chk_pend  = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_pend) begin
        chk_pend = 1'b0;
        chk("hi_after", hi_o, pend.hi);
        chk("lo_after", lo_o, pend.lo);
      end
      if (e_valid && !done_all) begin
        if (stall_o) stall_cnt++;
        if (rst || flushE || (!stall_o && !stallE)) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: instruction %h left E with no expectation", aluopE);
          end else begin
            pend = sb_q.pop_front();
            chk("stall_cycles", 32'(stall_cnt), 32'(pend.stall));
            chk("hilo_rd", hilo_rd_o, pend.rd);
            chk_pend = 1'b1;
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : driver
    logic [7:0] ops[9];
    logic [7:0] op;
    logic [31:0] a, b;
    int lat, fl;
    ops = '{ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU, ALUOP_MFHI, ALUOP_MFLO,
            ALUOP_MTHI, ALUOP_MTLO, OpNop};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);

    issue(ALUOP_MULT, 32'hffff_fffd, 32'd7, -1, 0, 0, -1);
    issue(ALUOP_DIVU, 32'd100, 32'd7, -1, 0, 0, -1);
    issue(ALUOP_DIV, 32'hffff_fff9, 32'd2, -1, 0, 0, -1);
    issue(ALUOP_DIV, 32'd5, 32'd0, -1, 0, 0, -1);
    issue(ALUOP_DIV, 32'h8000_0000, 32'hffff_ffff, -1, 0, 0, -1);
    issue(ALUOP_DIVU, 32'd12345, 32'd17, 10, 0, 0, -1);
    issue(ALUOP_MULTU, 32'hffff_ffff, 32'hffff_ffff, -1, 4, 3, -1);
    issue(ALUOP_MULT, 32'd1000, 32'hffff_fff0, 6, 4, 3, -1);
    issue(ALUOP_MTHI, 32'hdead_beef, 32'd0, -1, 0, 0, -1);
    issue(ALUOP_MFHI, 32'd0, 32'd0, -1, 0, 0, -1);
    issue(ALUOP_MTLO, 32'h1234_5678, 32'd0, 0, 0, 0, -1);
    issue(ALUOP_MFLO, 32'd0, 32'd0, -1, 0, 0, -1);
    issue(ALUOP_MULT, 32'd9, 32'd9, -1, 0, 0, 2);
    issue(OpNop, 32'd0, 32'd0, -1, 0, 0, -1);

    for (int n = 0; n < 120; n++) begin
      op  = ops[$urandom_range(0, 8)];
      a   = rand_val();
      b   = rand_val();
      lat = latency(op, b);
      fl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, lat + 1)) : -1;
      issue(op, a, b, fl, int'($urandom_range(0, lat + 1)), int'($urandom_range(0, 3)), -1);
    end

    @(posedge clk);
    #1;
    e_valid = 1'b0;
    aluopE  = OpNop;
    stallE  = 1'b0;
    flushE  = 1'b0;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
    done_all = 1'b1;
    if (!timed_out) chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
